// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle ops finish on acceptance; MUL/DIV iterate one bit per cycle.
// state | meaning:  IDLE accept request | CALC shift-add / restoring-divide step | DONE hold result
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             div_err
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, acc_r, q_r;
    logic [3:0]       sel_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH-1:0] s_res;
    logic             s_cout, s_ovf;
    logic [WIDTH:0]   wide;
    logic             is_iter;

    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] it_acc, it_q, fin_res;

    assign is_iter   = (alu_sel == 4'd2) || (alu_sel == 4'd3);
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    always_comb begin
        s_res  = '0;
        s_cout = 1'b0;
        s_ovf  = 1'b0;
        wide   = '0;
        case (alu_sel)
            4'd0: begin
                wide   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                s_res  = wide[WIDTH-1:0];
                s_cout = wide[WIDTH];
                s_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                // the extra top bit of the difference is the borrow
                wide   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
                s_res  = wide[WIDTH-1:0];
                s_cout = wide[WIDTH];
                s_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'd4:  begin s_res = {a[WIDTH-2:0], 1'b0};       s_cout = a[WIDTH-1]; end
            4'd5:  begin s_res = {1'b0, a[WIDTH-1:1]};       s_cout = a[0];       end
            4'd6:  begin s_res = {a[WIDTH-2:0], a[WIDTH-1]}; s_cout = a[WIDTH-1]; end
            4'd7:  begin s_res = {a[0], a[WIDTH-1:1]};       s_cout = a[0];       end
            4'd8:  s_res = a & b;
            4'd9:  s_res = a | b;
            4'd10: s_res = a ^ b;
            4'd11: s_res = ~(a | b);
            4'd12: s_res = ~(a & b);
            4'd13: s_res = ~(a ^ b);
            4'd14: s_res = {{(WIDTH-1){1'b0}}, a > b};
            4'd15: s_res = {{(WIDTH-1){1'b0}}, a == b};
            default: s_res = '0;
        endcase
    end

    // MUL keeps {acc_r, q_r} as the shifting product; DIV keeps remainder in acc_r, dividend/quotient in q_r
    always_comb begin
        mul_sum   = {1'b0, acc_r} + (q_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        div_shift = {acc_r, q_r[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_r});
        div_diff  = div_shift - {1'b0, b_r};
        if (sel_r == 4'd2) begin
            it_acc = mul_sum[WIDTH:1];
            it_q   = {mul_sum[0], q_r[WIDTH-1:1]};
        end else begin
            it_acc = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            it_q   = {q_r[WIDTH-2:0], div_ge};
        end
        fin_res = ((sel_r == 4'd3) && (b_r == '0)) ? {WIDTH{1'b1}} : it_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)          state_nxt = is_iter ? CALC : DONE;
            CALC: if (cnt_r == CW'(1))   state_nxt = DONE;
            DONE: if (out_ready)         state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            acc_r    <= '0;
            q_r      <= '0;
            sel_r    <= '0;
            cnt_r    <= '0;
            alu_out  <= '0;
            alu_cout <= 1'b0;
            zero     <= 1'b0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b;
                    sel_r <= alu_sel;
                    acc_r <= '0;
                    q_r   <= (alu_sel == 4'd2) ? b : a;
                    cnt_r <= CW'(WIDTH);
                    if (!is_iter) begin
                        alu_out  <= s_res;
                        alu_cout <= s_cout;
                        ovf      <= s_ovf;
                        div_err  <= 1'b0;
                        zero     <= (s_res == '0);
                        neg      <= s_res[WIDTH-1];
                    end
                end
                CALC: begin
                    acc_r <= it_acc;
                    q_r   <= it_q;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        alu_out  <= fin_res;
                        alu_cout <= (it_acc != '0);
                        ovf      <= 1'b0;
                        div_err  <= (sel_r == 4'd3) && (b_r == '0);
                        zero     <= (fin_res == '0);
                        neg      <= fin_res[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomized check of alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, out_valid, out_ready;
    logic [W-1:0] a, b, alu_out;
    logic [3:0]   alu_sel;
    logic         alu_cout, zero, neg, ovf, div_err;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .alu_sel(alu_sel),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
        .alu_cout(alu_cout), .zero(zero), .neg(neg), .ovf(ovf), .div_err(div_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        bit cout;
        bit ovf;
        bit derr;
        int lat;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int av, input int bv, input int cv, input int sel);
        exp_t e;
        int sa, sb, s;
        e.res = 0; e.cout = 0; e.ovf = 0; e.derr = 0; e.lat = 1;
        sa = (av >= 128) ? av - 256 : av;
        sb = (bv >= 128) ? bv - 256 : bv;
        case (sel)
            0: begin
                s = av + bv + cv; e.res = s % 256; e.cout = (s > 255);
                s = sa + sb + cv; e.ovf = (s > 127) || (s < -128);
            end
            1: begin
                s = av - bv - cv; e.res = (s + 512) % 256; e.cout = (av < bv + cv);
                s = sa - sb - cv; e.ovf = (s > 127) || (s < -128);
            end
            2: begin s = av * bv; e.res = s % 256; e.cout = (s > 255); e.lat = 9; end
            3: begin
                e.lat = 9;
                // a zero divisor leaves the whole dividend as remainder
                if (bv == 0) begin e.res = 255; e.derr = 1; e.cout = (av != 0); end
                else begin e.res = av / bv; e.cout = (av % bv) != 0; end
            end
            4: begin e.res = (av * 2) % 256;           e.cout = (av >= 128); end
            5: begin e.res = av / 2;                   e.cout = (av % 2) != 0; end
            6: begin e.res = (av * 2) % 256 + av / 128; e.cout = (av >= 128); end
            7: begin e.res = av / 2 + (av % 2) * 128;  e.cout = (av % 2) != 0; end
            8:  e.res = av & bv;
            9:  e.res = av | bv;
            10: e.res = av ^ bv;
            11: e.res = 255 - (av | bv);
            12: e.res = 255 - (av & bv);
            13: e.res = 255 - (av ^ bv);
            14: e.res = (av > bv) ? 1 : 0;
            default: e.res = (av == bv) ? 1 : 0;
        endcase
        return e;
    endfunction

    task automatic do_op(input int av, input int bv, input int cv, input int sel,
                         input int stall, input string tag);
        exp_t e;
        int   t, lat;
        bit   ready_busy;
        e = model(av, bv, cv, sel);
        t = 0;
        while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
        chk($sformatf("%s in_ready", tag), in_ready, 1);
        a = av[W-1:0]; b = bv[W-1:0]; cin = cv[0]; alu_sel = sel[3:0]; in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1; ready_busy = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_busy = 1;
            a = W'($urandom); b = W'($urandom); alu_sel = 4'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk($sformatf("%s latency", tag), lat, e.lat);
        chk($sformatf("%s busy in_ready", tag), {31'b0, ready_busy | in_ready}, 0);
        for (int k = 0; k <= stall; k++) begin
            chk($sformatf("%s[%0d] out_valid", tag, k), out_valid, 1);
            chk($sformatf("%s[%0d] alu_out", tag, k), alu_out, e.res);
            chk($sformatf("%s[%0d] alu_cout", tag, k), alu_cout, e.cout);
            chk($sformatf("%s[%0d] ovf", tag, k), ovf, e.ovf);
            chk($sformatf("%s[%0d] div_err", tag, k), div_err, e.derr);
            chk($sformatf("%s[%0d] zero", tag, k), zero, e.res == 0);
            chk($sformatf("%s[%0d] neg", tag, k), neg, e.res >= 128);
            if (k < stall) begin
                in_valid = 1'b1; a = W'($urandom); b = W'($urandom); alu_sel = 4'($urandom);
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("%s released", tag), {30'b0, out_valid, in_ready}, 1);
    endtask

    initial begin
        int hi;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; alu_sel = '0;
        #2;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset outputs", {alu_out, alu_cout, zero, neg, ovf, div_err}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("ready after reset", in_ready, 1);

        do_op(8'h0A, 8'h02, 0, 0, 0, "add");
        do_op(8'h02, 8'h0A, 0, 1, 0, "sub");
        do_op(8'h7F, 8'h01, 0, 0, 0, "add_ovf");
        do_op(8'hF6, 8'h0A, 0, 2, 1, "mul");
        do_op(8'h0A, 8'h00, 0, 3, 0, "div0");
        do_op(8'h0A, 8'h03, 0, 3, 0, "div3");
        do_op(8'hFF, 8'h00, 1, 1, 0, "sub_borrow_in");

        for (int s = 0; s < 16; s++) do_op(8'h0A, 8'h02, 0, s, 3, $sformatf("sweep%0d", s));

        for (int i = 0; i < 60; i++) begin
            int av, bv;
            av = $urandom_range(0, 255);
            bv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            do_op(av, bv, $urandom_range(0, 1), $urandom_range(0, 15),
                  $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        // abort a multiply midway through its iterations
        a = 8'hF6; b = 8'h0A; alu_sel = 4'd2; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort out_valid", out_valid, 0);
        chk("abort outputs", {alu_out, alu_cout, zero, neg, ovf, div_err}, 0);
        chk("abort in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort ready after release", in_ready, 1);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) hi++;
            @(posedge clk); #1;
        end
        chk("abort no stale result", hi, 0);
        do_op(8'h01, 8'h01, 0, 0, 0, "post_abort_add");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
